// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, FSM state type and helpers for the DDS wave engine
package dds_pkg;
    localparam logic [1:0] REG_FREQ     = 2'd0;
    localparam logic [1:0] REG_PHASE    = 2'd1;
    localparam logic [1:0] REG_WAVE_AMP = 2'd2;
    localparam logic [1:0] REG_CONTROL  = 2'd3;
    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_PHASE_CLR = 1;
    localparam int CTRL_OVR_CLR   = 2;
    localparam int AMP_UNITY = 256;
    localparam int WAVE_SINE   = 0;
    localparam int WAVE_SQUARE = 1;
    localparam int WAVE_TRI    = 2;
    localparam int WAVE_SAW    = 3;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    function automatic logic [8:0] sat_amp(input logic [8:0] a);
        return (a > 9'(AMP_UNITY)) ? 9'(AMP_UNITY) : a;
    endfunction
endpackage

// File: rtl/dds_wave_rom.sv
// dds_wave_rom: single-port synchronous waveform ROM, one-cycle registered read
module dds_wave_rom
    import dds_pkg::*;
#(
    parameter int DEPTH_W = 12,
    parameter int DATA_W = 8,
    parameter int TABLE_W = 9,
    parameter string INIT_FILE = "wave.mi"
) (
    input  logic               clk,
    input  logic               ce,
    input  logic [DEPTH_W-1:0] addr,
    output logic [DATA_W-1:0]  q
);
    localparam int SW = DEPTH_W - TABLE_W;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
    // The named image's tables are generated in logic; an empty name selects a linear ramp image
    localparam bit RAMP = (INIT_FILE == "");

    function automatic logic [DATA_W-1:0] word(input logic [DEPTH_W-1:0] a);
        logic [SW-1:0] w;
        logic [DATA_W-1:0] f, g, gi, h;
        logic [2*DATA_W-1:0] p;
        w = a[DEPTH_W-1:TABLE_W];
        f = DATA_W'({a[TABLE_W-1:0], {DATA_W{1'b0}}} >> TABLE_W);
        g = f << 1;
        gi = ~g;
        p = {{DATA_W{1'b0}}, g} * {{DATA_W{1'b0}}, gi};
        h = DATA_W'(p >> (DATA_W - 1));
        return RAMP ? a[DATA_W-1:0]
             : w == SW'(WAVE_SINE)   ? (f[DATA_W-1] ? MID - h : MID + h)
             : w == SW'(WAVE_SQUARE) ? (f[DATA_W-1] ? '0 : '1)
             : w == SW'(WAVE_TRI)    ? (f[DATA_W-1] ? gi : g)
             : w == SW'(WAVE_SAW)    ? f
             : MID;
    endfunction

    // Registered read, updated only when enabled
    always_ff @(posedge clk)
        if (ce) q <= word(addr);
endmodule

// File: rtl/dds_wave_engine.sv
// dds_wave_engine: multi-channel DDS core sharing one waveform ROM round-robin
module dds_wave_engine
    import dds_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PHASE_W = 32,
    parameter int ADDR_W = 9,
    parameter int WAVE_SEL_W = 3,
    parameter int DATA_W = 8,
    parameter string INIT_FILE = "wave.mi"
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [2:0]                 cfg_chan,
    input  logic [1:0]                 cfg_addr,
    input  logic [31:0]                cfg_data,
    output logic [CHANNELS*DATA_W-1:0] dout,
    output logic                       dout_valid,
    output logic                       overrun
);
    localparam int IDX_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW = DATA_W + 11;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic dcnt, rom_ce, drain_done, commit, cfg_fire, unused_cfg;
    logic [PHASE_W-1:0] sh_freq [CHANNELS], sh_phase [CHANNELS], nx_freq [CHANNELS], nx_phase [CHANNELS];
    logic [PHASE_W-1:0] freq [CHANNELS], phase [CHANNELS], acc [CHANNELS];
    logic [WAVE_SEL_W-1:0] sh_wave [CHANNELS], nx_wave [CHANNELS], wave [CHANNELS];
    logic [8:0] sh_amp [CHANNELS], nx_amp [CHANNELS], amp [CHANNELS];
    logic [CHANNELS-1:0] sh_en, nx_en, en, sh_clr, nx_clr;
    logic [PHASE_W-1:0] sum;
    logic [WAVE_SEL_W+ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q, lane_nx;
    logic [DATA_W-1:0] lane [CHANNELS];
    logic s1_vld, s1_en;
    logic [IDX_W-1:0] s1_idx;
    logic [8:0] s1_amp;
    logic signed [DATA_W:0] s;
    logic signed [PW-1:0] prod;

    assign unused_cfg = ^cfg_data;
    assign cfg_fire = cfg_valid && cfg_ready;
    assign commit = sample_en && cfg_ready;

    // Shadow values as they stand after this cycle's config write
    for (genvar c = 0; c < CHANNELS; c++) begin : g_cfg
        logic wr;
        assign wr = cfg_fire && cfg_chan == 3'(c);
        assign nx_freq[c]  = (wr && cfg_addr == REG_FREQ) ? cfg_data[PHASE_W-1:0] : sh_freq[c];
        assign nx_phase[c] = (wr && cfg_addr == REG_PHASE) ? cfg_data[PHASE_W-1:0] : sh_phase[c];
        assign nx_wave[c]  = (wr && cfg_addr == REG_WAVE_AMP) ? cfg_data[WAVE_SEL_W-1:0] : sh_wave[c];
        assign nx_amp[c]   = (wr && cfg_addr == REG_WAVE_AMP) ? sat_amp(cfg_data[16:8]) : sh_amp[c];
        assign nx_en[c]    = (wr && cfg_addr == REG_CONTROL) ? cfg_data[CTRL_ENABLE] : sh_en[c];
        assign nx_clr[c]   = (wr && cfg_addr == REG_CONTROL && cfg_data[CTRL_PHASE_CLR]) || sh_clr[c];
    end

    // Shadow registers; pending phase-clears are consumed by the commit
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sh_freq  <= '{default: '0};
            sh_phase <= '{default: '0};
            sh_wave  <= '{default: '0};
            sh_amp   <= '{default: 9'(AMP_UNITY)};
            sh_en    <= '0;
            sh_clr   <= '0;
        end else begin
            sh_freq  <= nx_freq;
            sh_phase <= nx_phase;
            sh_wave  <= nx_wave;
            sh_amp   <= nx_amp;
            sh_en    <= nx_en;
            sh_clr   <= commit ? '0 : nx_clr;
        end

    // Active settings change only at a sample commit, so one sample never mixes configs
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            freq  <= '{default: '0};
            phase <= '{default: '0};
            wave  <= '{default: '0};
            amp   <= '{default: 9'(AMP_UNITY)};
            en    <= '0;
        end else if (commit) begin
            freq  <= nx_freq;
            phase <= nx_phase;
            wave  <= nx_wave;
            amp   <= nx_amp;
            en    <= nx_en;
        end

    // Accumulators: cleared at commit on request, advanced once per sample as their channel issues
    always_ff @(posedge clk or posedge reset)
        if (reset) acc <= '{default: '0};
        else if (commit) begin
            for (int i = 0; i < CHANNELS; i++)
                if (nx_clr[i]) acc[i] <= '0;
        end else if (state == ISSUE) acc[idx] <= acc[idx] + freq[idx];

    assign sum = acc[idx] + phase[idx];
    assign rom_addr = {wave[idx], ADDR_W'(sum >> (PHASE_W - ADDR_W))};

    dds_wave_rom #(
        .DEPTH_W(WAVE_SEL_W + ADDR_W),
        .DATA_W(DATA_W),
        .TABLE_W(ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk(clk),
        .ce(rom_ce),
        .addr(rom_addr),
        .q(rom_q)
    );

    // Channel context travelling alongside the ROM read
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            s1_en  <= 1'b0;
            s1_amp <= '0;
        end else begin
            s1_vld <= rom_ce;
            s1_idx <= idx;
            s1_en  <= en[idx];
            s1_amp <= amp[idx];
        end

    assign s = $signed({1'b0, rom_q}) - $signed({1'b0, MID});
    assign prod = PW'(s) * PW'($signed({1'b0, s1_amp}));
    assign lane_nx = s1_en ? MID + DATA_W'(prod >>> 8) : MID;

    // Scaled samples collect per lane until every channel of the sample is ready
    always_ff @(posedge clk or posedge reset)
        if (reset) lane <= '{default: MID};
        else if (s1_vld) lane[s1_idx] <= lane_nx;

    // All lanes are published together with a one-cycle valid pulse
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            dout       <= {CHANNELS{MID}};
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= drain_done;
            if (drain_done)
                for (int i = 0; i < CHANNELS; i++) dout[i*DATA_W +: DATA_W] <= lane[i];
        end

    // Sticky overrun; a late tick beats a same-cycle clear
    always_ff @(posedge clk or posedge reset)
        if (reset) overrun <= 1'b0;
        else if (sample_en && state != IDLE) overrun <= 1'b1;
        else if (cfg_fire && cfg_addr == REG_CONTROL && cfg_data[CTRL_OVR_CLR]) overrun <= 1'b0;

    // FSM state, issue index and drain counter
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            dcnt  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= (state == ISSUE) ? idx + 1'b1 : '0;
            dcnt  <= (state == DRAIN) ? ~dcnt : 1'b0;
        end

    // Next state: issue every channel, then wait out the two pipeline stages
    always_comb
        state_nx = state == IDLE  ? (sample_en ? ISSUE : IDLE)
                 : state == ISSUE ? (idx == IDX_W'(CHANNELS - 1) ? DRAIN : ISSUE)
                 : (dcnt ? IDLE : DRAIN);

    // FSM outputs
    always_comb begin
        cfg_ready  = state == IDLE;
        rom_ce     = state == ISSUE;
        drain_done = state == DRAIN && dcnt;
    end
endmodule
